// File: rtl/mech_force_fanout_pkg.sv
// ============================================================================
// mech_force_pkg : shared widths, saturation limits and defaults for the
//                  force fan-out path.   Rev 1.0
// ============================================================================
`default_nettype none

package mech_force_pkg;

  localparam int c_DATA_W    = 18;
  localparam int c_PROD_W    = 36;
  localparam int c_DEF_PCW   = 10;
  localparam int c_DEF_LEN   = 1024;
  localparam int c_DEF_SHIFT = 17;

  typedef logic signed [c_DATA_W-1:0] data_t;
  typedef logic signed [c_PROD_W-1:0] prod_t;

  localparam data_t c_SAT_MAX = {1'b0, {(c_DATA_W-1){1'b1}}};
  localparam data_t c_SAT_MIN = {1'b1, {(c_DATA_W-1){1'b0}}};

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mech_force_fanout_sat_shift.sv
// ============================================================================
// sat_shift : arithmetic right shift of a product followed by a clamp to the
//             data width, with an overflow indication.   Rev 1.0
// ============================================================================
`default_nettype none

module sat_shift
  import mech_force_pkg::*;
#(
  parameter int SHIFT = c_DEF_SHIFT
) (
  input  logic signed [c_PROD_W-1:0] i_p,
  output logic signed [c_DATA_W-1:0] o_y,
  output logic                       o_ovf
);

  prod_t w_s;
  logic  w_hi;
  logic  w_lo;

  always_comb begin
    w_s   = i_p >>> SHIFT;
    w_hi  = (w_s > prod_t'(c_SAT_MAX));
    w_lo  = (w_s < prod_t'(c_SAT_MIN));
    o_ovf = w_hi | w_lo;
    if (w_hi)
      o_y = c_SAT_MAX;
    else if (w_lo)
      o_y = c_SAT_MIN;
    else
      o_y = w_s[c_DATA_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/mech_force_fanout.sv
// ============================================================================
// mech_force_fanout : streams y[i] = sat((k[i] * v) >>> SHIFT) for i=0..LEN-1,
//                     with k[i] fetched from a one-cycle external memory.  Rev 1.0
// ============================================================================
`default_nettype none

module mech_force_fanout
  import mech_force_pkg::*;
#(
  parameter int PCW   = c_DEF_PCW,
  parameter int LEN   = c_DEF_LEN,
  parameter int SHIFT = c_DEF_SHIFT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [c_DATA_W-1:0] v,
  input  logic signed [c_DATA_W-1:0] k_in,
  output logic        [PCW-1:0]      k_in_addr,
  output logic signed [c_DATA_W-1:0] y,
  output logic        [PCW-1:0]      y_addr,
  output logic                       y_valid,
  output logic                       done,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam logic [PCW-1:0] c_LAST = PCW'(LEN - 1);

  logic [0:0]     r_state;
  logic [0:0]     w_next;
  logic [PCW-1:0] r_pc;
  data_t          r_vh;
  logic           w_last;
  logic           w_flush;

  logic           r_v1, r_v2, r_v3;
  logic           r_l1, r_l2, r_l3;
  logic [PCW-1:0] r_a1, r_a2, r_a3;
  data_t          r_s1, r_s2;
  data_t          r_k;
  prod_t          r_p;
  data_t          w_y;
  logic           w_ovf;
  logic           w_sat;

  assign w_last  = (r_state == c_ST_RUN) && (r_pc == c_LAST);
  // A start after the final address has gone out lets the old frame drain.
  assign w_flush = start && (r_state == c_ST_RUN) && !w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_pc    <= '0;
      r_vh    <= '0;
    end else begin
      r_state <= w_next;
      if (start) begin
        r_pc <= '0;
        r_vh <= v;
      end else if (r_state == c_ST_RUN) begin
        r_pc <= w_last ? '0 : r_pc + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (start)
      w_next = c_ST_RUN;
    else if (w_last)
      w_next = c_ST_IDLE;
  end

  always_comb begin
    busy      = (r_state == c_ST_RUN);
    k_in_addr = busy ? r_pc : '0;
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
      r_l3 <= 1'b0;
    end else begin
      r_v1 <= busy;
      r_l1 <= w_last;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      r_v3 <= r_v2;
      r_l3 <= r_l2;
    end
  end

  // The scalar rides with each sample so a back-to-back frame cannot corrupt
  // the tail of the previous one.
  always_ff @(posedge clk) begin
    r_a1 <= r_pc;
    r_s1 <= r_vh;
    r_a2 <= r_a1;
    r_s2 <= r_s1;
    r_k  <= k_in;
    r_a3 <= r_a2;
    r_p  <= r_k * r_s2;
  end

  sat_shift #(
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .i_p   (r_p),
    .o_y   (w_y),
    .o_ovf (w_ovf)
  );

  assign w_sat = r_v3 && !w_flush && w_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      y        <= '0;
      y_addr   <= '0;
      y_valid  <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      y_valid <= r_v3 && !w_flush;
      done    <= r_l3 && !w_flush;
      if (r_v3) begin
        y      <= w_y;
        y_addr <= r_a3;
      end
      if (start)
        sat_flag <= w_sat;
      else if (w_sat)
        sat_flag <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mech_force_fanout.sv
// ============================================================================
// tb_mech_force_fanout : scoreboard bench for two configurations of the
//                        force fan-out block.   Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mech_force_fanout;
  import mech_force_pkg::*;

  localparam int c_LEN_A = 8;
  localparam int c_SH_A  = 17;
  localparam int c_LEN_B = 1;
  localparam int c_SH_B  = 0;

  typedef struct {
    int fid;
    int cyc;
    int addr;
    int y;
    bit dn;
    bit sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              st   [2];
  logic signed [17:0] vin [2];
  logic signed [17:0] kin [2];
  logic signed [17:0] y_o [2];
  logic              yv   [2];
  logic              dn   [2];
  logic              bz   [2];
  logic              sf   [2];
  logic [3:0]        ka_a, ya_a;
  logic [0:0]        ka_b, ya_b;

  int   mem [2][16];
  exp_t q   [2][$];
  int   s_prev [2];
  int   cfid   [2];
  bit   act    [2];
  bit   msat   [2];
  int   fid_cnt = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  mech_force_fanout #(.PCW(4), .LEN(c_LEN_A), .SHIFT(c_SH_A)) u_a (
    .clk(clk), .reset(rst), .start(st[0]), .v(vin[0]), .k_in(kin[0]),
    .k_in_addr(ka_a), .y(y_o[0]), .y_addr(ya_a), .y_valid(yv[0]),
    .done(dn[0]), .busy(bz[0]), .sat_flag(sf[0])
  );

  mech_force_fanout #(.PCW(1), .LEN(c_LEN_B), .SHIFT(c_SH_B)) u_b (
    .clk(clk), .reset(rst), .start(st[1]), .v(vin[1]), .k_in(kin[1]),
    .k_in_addr(ka_b), .y(y_o[1]), .y_addr(ya_b), .y_valid(yv[1]),
    .done(dn[1]), .busy(bz[1]), .sat_flag(sf[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    kin[0] <= 18'(mem[0][ka_a]);
    kin[1] <= 18'(mem[1][ka_b]);
  end

  function automatic int len_of(input int d);
    return (d == 0) ? c_LEN_A : c_LEN_B;
  endfunction

  function automatic int sh_of(input int d);
    return (d == 0) ? c_SH_A : c_SH_B;
  endfunction

  function automatic int rnd18();
    logic [17:0] r;
    r = 18'($urandom);
    return int'($signed(r));
  endfunction

  function automatic int rndk();
    return int'($urandom_range(262142, 0)) - 131071;
  endfunction

  task automatic chk(input string nm, input longint got, input longint want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    st[0]  = 1'b0;
    st[1]  = 1'b0;
    vin[0] = 18'(rnd18());
    vin[1] = 18'(rnd18());
  endtask

  // Expected frame: y[i] = clamp(floor(k[i]*v / 2^shift)) at cycle S+5+i.
  task automatic issue_start(input int d, input int vv);
    exp_t   e;
    exp_t   keep[$];
    longint p, s;
    int     l;
    l = len_of(d);
    if (act[d] && (cyc - s_prev[d]) < l) begin
      keep = {};
      for (int j = 0; j < q[d].size(); j++)
        if (q[d][j].fid != cfid[d] || q[d][j].cyc <= cyc)
          keep.push_back(q[d][j]);
      q[d] = keep;
    end
    fid_cnt++;
    cfid[d]   = fid_cnt;
    s_prev[d] = cyc;
    act[d]    = 1'b1;
    for (int i = 0; i < l; i++) begin
      p = longint'(mem[d][i]) * longint'(vv);
      s = p >>> sh_of(d);
      e.fid  = fid_cnt;
      e.cyc  = cyc + 5 + i;
      e.addr = i;
      e.sat  = (s > 131071) || (s < -131072);
      e.y    = (s > 131071) ? 131071 : (s < -131072) ? -131072 : int'(s);
      e.dn   = (i == l - 1);
      q[d].push_back(e);
    end
    st[d]  = 1'b1;
    vin[d] = 18'(vv);
  endtask

  task automatic mon(input int d, input logic v_, input logic signed [17:0] yy,
                     input int ya, input logic dn_, input logic sf_, input logic st_);
    exp_t e;
    if (v_) begin
      n_chk++;
      if (q[d].size() == 0) begin
        n_err++;
        $display("FAIL dut%0d unexpected_y_valid: got y=%0d addr=%0d expected none (cycle %0d)",
                 d, yy, ya, cyc);
      end else begin
        e = q[d].pop_front();
        chk($sformatf("dut%0d y[%0d]", d, e.addr), yy, e.y);
        chk($sformatf("dut%0d y_addr", d), ya, e.addr);
        chk($sformatf("dut%0d y_cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d done", d), dn_, e.dn);
        msat[d] = msat[d] | e.sat;
      end
    end else begin
      chk($sformatf("dut%0d done_without_valid", d), dn_, 0);
    end
    chk($sformatf("dut%0d sat_flag", d), sf_, msat[d]);
    if (st_) msat[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, yv[0], y_o[0], int'(ya_a), dn[0], sf[0], st[0]);
      mon(1, yv[1], y_o[1], int'(ya_b), dn[1], sf[1], st[1]);
    end
  end

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst dut%0d y", d), y_o[d], 0);
      chk($sformatf("rst dut%0d y_valid", d), yv[d], 0);
      chk($sformatf("rst dut%0d done", d), dn[d], 0);
      chk($sformatf("rst dut%0d busy", d), bz[d], 0);
      chk($sformatf("rst dut%0d sat_flag", d), sf[d], 0);
    end
    chk("rst k_in_addr a", ka_a, 0);
    chk("rst y_addr a", ya_a, 0);
    chk("rst k_in_addr b", ka_b, 0);
    chk("rst y_addr b", ya_b, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain dut0 pending", q[0].size(), 0);
    chk("drain dut1 pending", q[1].size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    vin[0] = '0;  vin[1] = '0;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; msat[d] = 1'b0; s_prev[d] = 0; cfid[d] = 0;
      for (int i = 0; i < 16; i++) mem[d][i] = 0;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset();

    // Basic frame with address-issue timing
    mem[0][0] = 65536; mem[0][1] = -65536; mem[0][2] = 131071; mem[0][3] = 0;
    for (int i = 4; i < 8; i++) mem[0][i] = rndk();
    tick();
    issue_start(0, 65536);
    for (int i = 0; i < c_LEN_A; i++) begin
      tick();
      @(negedge clk);
      chk("busy during run", bz[0], 1);
      chk("k_in_addr during run", ka_a, i);
    end
    tick();
    @(negedge clk);
    chk("busy after run", bz[0], 0);
    chk("k_in_addr idle", ka_a, 0);
    drain();

    // Truncation toward minus infinity
    for (int i = 0; i < 8; i++) mem[0][i] = 1;
    issue_start(0, -1);
    drain();
    issue_start(0, 1);
    drain();

    // Saturation on the single-mode, unshifted instance
    mem[1][0] = 2;
    issue_start(1, 131071);
    drain();
    repeat (3) tick();
    mem[1][0] = -2;
    issue_start(1, 131071);
    drain();
    mem[1][0] = 3;
    issue_start(1, 5);
    drain();

    // Restart three cycles into a frame
    for (int i = 0; i < 8; i++) mem[0][i] = rndk();
    issue_start(0, rnd18());
    repeat (3) tick();
    issue_start(0, rnd18());
    drain();

    // Back-to-back frames
    issue_start(0, rnd18());
    repeat (c_LEN_A) tick();
    issue_start(0, rnd18());
    drain();

    // Randomised start spacing: restarts, back-to-back and idle gaps
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 8; i++) mem[0][i] = rndk();
      mem[1][0] = rndk();
      for (int n = 0; n < 8; n++) begin
        repeat ($urandom_range(14, 1)) tick();
        issue_start(0, rnd18());
        if ($urandom_range(1, 0) == 1) issue_start(1, rnd18());
      end
      drain();
    end

    // Reset in the middle of a frame
    for (int i = 0; i < 8; i++) mem[0][i] = rndk();
    issue_start(0, rnd18());
    repeat (6) tick();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      act[d]  = 1'b0;
      msat[d] = 1'b0;
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset();
    repeat (15) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mech_force_fanout.md
# mech_force_fanout

Distributes one scalar per frame across a vector of mechanical modes: for each mode index i it streams y[i] = k[i]·v, with k[i] read from an external coefficient memory. It is the reverse of the dot-product path in the resonator simulator. That path collapses per-mode positions into one cavity drive term. This block spreads one cavity-derived force term, such as |V|² sampled at frame start, back onto the per-mode drive inputs of the resonator bank.

## Interface
- `pcw`, 10: address/index width; maximum frame length is 2^pcw.
- `len`, 1024: number of modes per frame, 1..2^pcw.
- `shift`, 17: right shift applied to the 36-bit product before saturation to 18 bits; valid range 0..18.
- `clk`  in  1: clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle frame start; samples `v`.
- `v`  in  18 signed: scalar force term.
- `k_in`  in  18 signed: external coefficient data; must never be −131072.
- `k_in_addr`  out  pcw: external coefficient address.
- `y`  out  18 signed: per-mode product.
- `y_addr`  out  pcw: mode index of `y`.
- `y_valid`  out  1: `y`/`y_addr` valid.
- `done`  out  1: one-cycle pulse coincident with the last `y_valid` of a frame.
- `busy`  out  1: addresses being issued.
- `sat_flag`  out  1: sticky; set if any product in the current frame saturated.

## Operation
- **Reset values:** pc=0, `k_in_addr`=0, `busy`=0, `y`=0, `y_addr`=0, `y_valid`=0, `done`=0, `sat_flag`=0. The held scalar register is also 0.
- **States:** IDLE (`busy`=0) and RUN (`busy`=1).
  - `start` in any state: hold `v`, set pc=0, enter RUN, clear `sat_flag`, and flush all in-flight pipeline valid bits. No stale `y_valid` or `done` is emitted after a restart.
  - In RUN: `k_in_addr`=pc and pc increments each cycle. After pc=len−1 is issued, return to IDLE with pc=0.
  - In IDLE: `k_in_addr` holds 0.
- **External memory:** synchronous, one cycle. `k_in` presents mem[A] the cycle after A appears on `k_in_addr`.
- **Arithmetic:**
  - p = k·v_hold, 36-bit signed.
  - s = p >>> shift, arithmetic shift (truncation toward −∞).
  - y = s clamped to [−131072, 131071].
  - When clamping occurs on a valid sample, set `sat_flag`.
- **Index tracking:** the mode index travels with the data through the pipeline, so `y_addr` always equals the address that fetched the coefficient.
- **`start` and `reset` in the same cycle:** `reset` wins.
- **`reset` mid-frame:** abort immediately; all outputs return to their reset values on the next cycle.
- **`start` while IDLE with `len`=1:** exactly one output and one `done`.

## Timing
Take `start` high in cycle S.

- **Address issue:** `busy`=1 in cycles S+1..S+len. `k_in_addr`=i in cycle S+1+i.
- **Pipeline stages:**
  - address in cycle t;
  - `k_in` valid in t+1;
  - `k_in` registered in t+2;
  - product registered in t+3;
  - shifted/saturated `y` registered in t+4.
- **Output window:** `y_valid`=1 with `y_addr`=i in cycle S+5+i, for i=0..len−1.
- **End of frame:** `done`=1 in cycle S+4+len, together with the last `y_valid`.
- **Back-to-back frames:** `start` at S+len gives continuous `y_valid` with no gap. The first frame completes, including its `done`, because its final address was already issued.
  - Restart rule: a `start` arriving while `busy`=1 (i.e. at or before S+len−1) flushes per the restart rule in Operation.
- **`v` changes:** no effect on products except when sampled by `start`.

## Structure
- **Shared package (`mech_force_pkg`):**
  - data width 18;
  - product width 36;
  - saturation limits ±131071/−131072;
  - default `pcw`/`len`/`shift`.
- **Sub-module `sat_shift`:** combinational arithmetic shift plus clamp, with an overflow indication. It is reused by other fixed-point paths.
- **Pipeline registers:** the valid/index pipeline is built from plain registers, not a generic delay line, so the flush is explicit.

## Test plan
- **Basic frame:** `len`=4, `shift`=17, memory k={65536, −65536, 131071, 0}, `v`=65536 sampled at start → `y`={32768, −32768, 65535, 0} with `y_addr` 0..3 in cycles S+5..S+8. `done` in S+8; `sat_flag`=0.
- **Saturation:** `shift`=0, k[0]=2, `v`=131071 → `y`=131071. k[1]=−2 → `y`=−131072. `sat_flag`=1 from the first saturated output until the next `start`.
- **Truncation:** `shift`=17, k=1, `v`=−1 → `y`=−1. k=1, `v`=1 → `y`=0.
- **Restart mid-frame:** `len`=8, second `start` at S+3 → no `y_valid` with `y_addr`≥1 from the first frame. Addresses restart at 0 in S+4; outputs resume at S+8 with the new `v`; exactly one `done`, at S+15.
- **Back-to-back:** `start` at S and at S+len → 2·`len` consecutive `y_valid` cycles, two `done` pulses, and `y_addr` wrapping len−1→0.
- **Reset mid-frame:** `reset` at S+6 → all outputs at reset values in S+7. No further `y_valid` until a new `start`.
